// File: rtl/serial_tx.sv
// serial_tx: parallel-to-serial frame transmitter.
// Frame = start bit (0), DATA_W data bits LSB-first, optional even-parity
// bit, stop bit (1). Every serial bit is held for CLKS_PER_BIT clocks.
//
// Handshake: a word is accepted on any rising edge where tx_valid and
// tx_ready are both 1. tx_ready depends only on the state (and reset),
// never on tx_valid; tx_data is ignored at all other times.
module serial_tx #(
    parameter int DATA_W       = 8,
    parameter int CLKS_PER_BIT = 4,
    parameter int PARITY_EN    = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic              d_out,
    output logic              busy
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] shift_reg;
    logic [DATA_W-1:0] shift_next;
    logic              parity_bit;
    logic              bit_done;
    logic              last_bit;
    logic              accept;

    // Bit-period and data-bit terminal counts, plus the next data bit to drive
    always_comb begin
        bit_done   = (bit_cnt == CNT_W'(CLKS_PER_BIT - 1));
        last_bit   = (bit_idx == IDX_W'(DATA_W - 1));
        shift_next = shift_reg >> 1;
        tx_ready   = (state == IDLE) && !reset;
        accept     = tx_ready && tx_valid;
    end

    // Frame sequencer: state, counters, shift register and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            parity_bit <= 1'b0;
            d_out      <= 1'b1;
            busy       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // Counters stay parked at 0 while idle
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    if (accept) begin
                        state      <= START;
                        shift_reg  <= tx_data;
                        parity_bit <= ^tx_data;
                        d_out      <= 1'b0;
                        busy       <= 1'b1;
                    end
                end

                START: begin
                    if (bit_done) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                        bit_idx <= '0;
                        d_out   <= shift_reg[0];
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                DATA: begin
                    if (bit_done) begin
                        bit_cnt <= '0;
                        if (last_bit) begin
                            bit_idx <= '0;
                            if (PARITY_EN != 0) begin
                                state <= PARITY;
                                d_out <= parity_bit;
                            end else begin
                                state <= STOP;
                                d_out <= 1'b1;
                            end
                        end else begin
                            bit_idx   <= bit_idx + IDX_W'(1);
                            shift_reg <= shift_next;
                            d_out     <= shift_next[0];
                        end
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                PARITY: begin
                    if (bit_done) begin
                        state   <= STOP;
                        bit_cnt <= '0;
                        d_out   <= 1'b1;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                STOP: begin
                    if (bit_done) begin
                        state   <= IDLE;
                        bit_cnt <= '0;
                        d_out   <= 1'b1;
                        busy    <= 1'b0;
                    end else begin
                        bit_cnt <= bit_cnt + CNT_W'(1);
                    end
                end

                default: begin
                    state   <= IDLE;
                    bit_cnt <= '0;
                    bit_idx <= '0;
                    d_out   <= 1'b1;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: scoreboard bench for serial_tx.
// dut  : default parameters (8 data bits, 4 clocks/bit, even parity).
// dut2 : 8 data bits, 1 clock/bit, no parity.
// Expected d_out samples (one per clock) are queued when a word is
// accepted and popped every cycle the DUT reports busy.
module tb_serial_tx;

    logic       clk;
    logic       reset;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       d_out;
    logic       busy;

    logic [7:0] tx_data2;
    logic       tx_valid2;
    logic       tx_ready2;
    logic       d_out2;
    logic       busy2;

    logic       exp_q[$];
    logic       exp2_q[$];
    int         n_checks;
    int         n_errors;
    bit         mon_en;

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_EN(1)) dut (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .tx_ready (tx_ready),
        .d_out    (d_out),
        .busy     (busy)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_EN(0)) dut2 (
        .clk      (clk),
        .reset    (reset),
        .tx_data  (tx_data2),
        .tx_valid (tx_valid2),
        .tx_ready (tx_ready2),
        .d_out    (d_out2),
        .busy     (busy2)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference frame: start, data LSB-first, optional even parity, stop
    function automatic void push_frame(input logic [7:0] d, input int cpb,
                                       input bit par_en, input bit sel);
        logic bits[$];
        bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) bits.push_back(d[i]);
        if (par_en) begin
            logic p;
            p = 1'b0;
            for (int i = 0; i < 8; i++) p = p ^ d[i];
            bits.push_back(p);
        end
        bits.push_back(1'b1);
        foreach (bits[b]) begin
            for (int c = 0; c < cpb; c++) begin
                if (sel) exp2_q.push_back(bits[b]);
                else     exp_q.push_back(bits[b]);
            end
        end
    endfunction

    // Monitor for dut: pops one expected bit per busy cycle, idle line otherwise
    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) begin
                check("ready_in_reset", {31'd0, tx_ready}, 32'd0);
            end else begin
                check("busy", {31'd0, busy}, {31'd0, exp_q.size() != 0});
                if (exp_q.size() != 0) begin
                    logic e;
                    e = exp_q.pop_front();
                    check("d_out", {31'd0, d_out}, {31'd0, e});
                    check("ready_busy", {31'd0, tx_ready}, 32'd0);
                end else begin
                    check("d_out_idle", {31'd0, d_out}, 32'd1);
                    check("ready_idle", {31'd0, tx_ready}, 32'd1);
                end
            end
        end
    end

    // Driver: present a word, wait for tx_ready, queue its frame at the accept edge
    task automatic send(input logic [7:0] d);
        int n;
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = d;
        n = 0;
        while (!tx_ready && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!tx_ready) check("send_timeout", 32'd1, 32'd0);
        @(posedge clk);
        push_frame(d, 4, 1'b1, 1'b0);
        #1;
        tx_valid = 1'b0;
        tx_data  = 8'($urandom_range(0, 255));
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", 32'd1, 32'd0);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        int gap;
        n_checks  = 0;
        n_errors  = 0;
        mon_en    = 1'b1;
        reset     = 1'b1;
        tx_valid  = 1'b1;   // must not be accepted while in reset
        tx_data   = 8'hEE;
        tx_valid2 = 1'b0;
        tx_data2  = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        reset    = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        check("rst_d_out", {31'd0, d_out}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, tx_ready}, 32'd1);

        // Basic frames, parity 0/1 and all-zero data
        send(8'hA5);
        wait_idle();
        send(8'h07);
        wait_idle();
        send(8'h00);
        wait_idle();

        // Held tx_valid: second word accepted on the first idle cycle
        @(posedge clk); #1;
        tx_valid = 1'b1;
        tx_data  = 8'h3C;
        @(posedge clk);
        push_frame(8'h3C, 4, 1'b1, 1'b0);
        #1;
        tx_data = 8'hC3;
        gap = 0;
        do begin
            @(posedge clk); #1;
            gap++;
        end while (!tx_ready && gap < 200);
        check("b2b_gap", 32'(gap), 32'd44);
        @(posedge clk);
        push_frame(8'hC3, 4, 1'b1, 1'b0);
        #1;
        tx_valid = 1'b0;
        wait_idle();

        // Input changes while not ready must not disturb the frame
        send(8'h11);
        repeat (14) @(posedge clk);
        #1;
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        repeat (10) @(posedge clk);
        #1;
        tx_valid = 1'b0;
        wait_idle();

        // Reset pulse during the third data bit aborts the frame
        send(8'hB7);
        repeat (13) @(posedge clk);
        #1;
        reset    = 1'b1;
        tx_valid = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        reset    = 1'b0;
        tx_valid = 1'b0;
        @(negedge clk);
        check("abort_d_out", {31'd0, d_out}, 32'd1);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_ready", {31'd0, tx_ready}, 32'd1);
        send(8'h5A);
        wait_idle();

        // Random words with random gaps
        for (int i = 0; i < 4; i++) begin
            send(8'($urandom_range(0, 255)));
            gap = $urandom_range(0, 3);
            repeat (gap) @(posedge clk);
        end
        wait_idle();

        // No-parity, one clock per bit instance
        @(posedge clk); #1;
        check("d2_ready", {31'd0, tx_ready2}, 32'd1);
        tx_valid2 = 1'b1;
        tx_data2  = 8'h81;
        @(posedge clk);
        push_frame(8'h81, 1, 1'b0, 1'b1);
        check("d2_frame_len", 32'(exp2_q.size()), 32'd10);
        #1;
        tx_valid2 = 1'b0;
        while (exp2_q.size() != 0) begin
            logic e;
            @(negedge clk);
            e = exp2_q.pop_front();
            check("d2_d_out", {31'd0, d_out2}, {31'd0, e});
            check("d2_busy", {31'd0, busy2}, 32'd1);
        end
        @(negedge clk);
        check("d2_idle_busy", {31'd0, busy2}, 32'd0);
        check("d2_idle_d_out", {31'd0, d_out2}, 32'd1);
        check("d2_idle_ready", {31'd0, tx_ready2}, 32'd1);

        check("queue_empty", 32'(exp_q.size()), 32'd0);
        mon_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
